// File: rtl/rom_load_sequencer.sv
// Multi-region boot loader sequencer: runs up to NUM_REGIONS flash loads per slot-valid edge and
// turns the loader toggle handshake into BRAM write strobes. Watchdog: ROM_LOAD_WATCHDOG_EN.
`timescale 1ns/1ps
module rom_load_sequencer #(
  parameter int unsigned NUM_REGIONS = 2,
  parameter int unsigned A_BITS      = 14,
  parameter int unsigned OFS_BITS    = 24
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            ena_1khz,
  input  logic                            slot_valid,
  input  logic [NUM_REGIONS*16-1:0]       reg_start_addr,
  input  logic [NUM_REGIONS*OFS_BITS-1:0] reg_flash_ofs,
  input  logic [NUM_REGIONS*16-1:0]       reg_amount,
  output logic                            ld_start,
  output logic [15:0]                     ld_start_addr,
  output logic [OFS_BITS-1:0]             ld_flash_ofs,
  output logic [15:0]                     ld_amount,
  input  logic                            ld_busy,
  input  logic                            ld_req,
  output logic                            ld_ack,
  input  logic [A_BITS-1:0]               ld_a,
  input  logic [7:0]                      ld_q,
  output logic                            wr_strobe,
  output logic [A_BITS-1:0]               wr_addr,
  output logic [7:0]                      wr_data,
  output logic [2:0]                      wr_region,
  output logic                            busy,
  output logic                            done,
  output logic                            error,
  output logic                            c64_reset_hold
);

  typedef enum logic [2:0] {
    StIdle,
    StSelect,
    StStart,
    StWaitBusy,
    StWaitDone,
    StNext,
    StFinish
  } state_e;

  localparam logic [2:0] LastIdx = 3'(NUM_REGIONS - 1);

  state_e      state;
  logic [2:0]  idx;
  logic        sv_old;
  logic        sv_armed;
  logic        req_old;
  logic        trigger;
  logic        toggle;
  logic        wd_fire;

  logic [15:0]         cur_addr;
  logic [15:0]         cur_amount;
  logic [OFS_BITS-1:0] cur_ofs;

  // sv_armed blocks a trigger after reset until slot_valid has been seen low once.
  assign trigger = slot_valid & ~sv_old & sv_armed;
  assign toggle  = ld_req ^ req_old;

  assign cur_addr   = reg_start_addr[16*idx +: 16];
  assign cur_amount = reg_amount[16*idx +: 16];
  assign cur_ofs    = reg_flash_ofs[OFS_BITS*idx +: OFS_BITS];

`ifdef ROM_LOAD_WATCHDOG_EN
  localparam logic [11:0] WdLimit = 12'd2000;

  logic [11:0] wd_cnt;
  logic        error_q;

  assign wd_fire = ((state == StWaitBusy) || (state == StWaitDone)) && (wd_cnt == WdLimit);
  assign error   = error_q;
`else
  logic unused_ena_1khz;

  assign unused_ena_1khz = ena_1khz;
  assign wd_fire         = 1'b0;
  assign error           = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= StIdle;
      idx           <= '0;
      sv_old        <= 1'b0;
      sv_armed      <= 1'b0;
      ld_start      <= 1'b0;
      ld_start_addr <= '0;
      ld_flash_ofs  <= '0;
      ld_amount     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
`ifdef ROM_LOAD_WATCHDOG_EN
      wd_cnt        <= '0;
      error_q       <= 1'b0;
`endif
    end else begin
      sv_old   <= slot_valid;
      ld_start <= 1'b0;
      if (!slot_valid) begin
        sv_armed <= 1'b1;
      end

      unique case (state)
        StIdle: begin
          if (trigger) begin
            idx   <= '0;
            done  <= 1'b0;
            busy  <= 1'b1;
            state <= StSelect;
          end
        end
        StSelect: begin
          if (cur_amount == 16'd0) begin
            state <= StNext;
          end else begin
            ld_start_addr <= cur_addr;
            ld_flash_ofs  <= cur_ofs;
            ld_amount     <= cur_amount;
            ld_start      <= 1'b1;
            state         <= StStart;
          end
        end
        StStart: begin
          state <= StWaitBusy;
        end
        StWaitBusy: begin
          if (wd_fire) begin
            state <= StNext;
          end else if (ld_busy) begin
            state <= StWaitDone;
          end
        end
        StWaitDone: begin
          if (wd_fire || !ld_busy) begin
            state <= StNext;
          end
        end
        StNext: begin
          if (idx == LastIdx) begin
            state <= StFinish;
          end else begin
            idx   <= idx + 3'd1;
            state <= StSelect;
          end
        end
        StFinish: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase

`ifdef ROM_LOAD_WATCHDOG_EN
      // Counter restarts as each region enters its busy wait; error is sticky until a new trigger.
      if (state == StStart) begin
        wd_cnt <= '0;
      end else if ((state == StWaitBusy || state == StWaitDone) && ena_1khz && !wd_fire) begin
        wd_cnt <= wd_cnt + 12'd1;
      end
      if (state == StIdle && trigger) begin
        error_q <= 1'b0;
      end else if (wd_fire) begin
        error_q <= 1'b1;
      end
`endif
    end
  end

  // Write path runs independently of the sequencer state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_old   <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      wr_region <= '0;
    end else begin
      req_old   <= ld_req;
      wr_strobe <= toggle;
      if (toggle) begin
        wr_addr   <= ld_a;
        wr_data   <= ld_q;
        wr_region <= idx;
      end
    end
  end

  assign ld_ack         = req_old;
  assign c64_reset_hold = ~done;

endmodule

// File: tb/tb_rom_load_sequencer.sv
// Directed self-checking bench for rom_load_sequencer (NUM_REGIONS=2); watchdog scenario follows
// whether ROM_LOAD_WATCHDOG_EN is defined.
`timescale 1ns/1ps
module tb_rom_load_sequencer;

  localparam int A_BITS   = 14;
  localparam int OFS_BITS = 24;

  logic                clk = 1'b0;
  logic                reset;
  logic                ena_1khz;
  logic                slot_valid;
  logic [15:0]         sa [2];
  logic [OFS_BITS-1:0] of [2];
  logic [15:0]         am [2];
  logic                ld_start;
  logic [15:0]         ld_start_addr;
  logic [OFS_BITS-1:0] ld_flash_ofs;
  logic [15:0]         ld_amount;
  logic                ld_busy;
  logic                ld_req;
  logic                ld_ack;
  logic [A_BITS-1:0]   ld_a;
  logic [7:0]          ld_q;
  logic                wr_strobe;
  logic [A_BITS-1:0]   wr_addr;
  logic [7:0]          wr_data;
  logic [2:0]          wr_region;
  logic                busy;
  logic                done;
  logic                error;
  logic                c64_reset_hold;

  int n_checks = 0;
  int n_pass   = 0;

  // Monitor state
  int n_str    = 0;
  int n_r0     = 0;
  int n_r1     = 0;
  int n_starts = 0;
  int mon_err  = 0;
  int cur_i    = 0;
  bit mon_chk  = 1'b0;

  always #5 clk = ~clk;

  rom_load_sequencer #(
    .NUM_REGIONS(2),
    .A_BITS     (A_BITS),
    .OFS_BITS   (OFS_BITS)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ena_1khz      (ena_1khz),
    .slot_valid    (slot_valid),
    .reg_start_addr({sa[1], sa[0]}),
    .reg_flash_ofs ({of[1], of[0]}),
    .reg_amount    ({am[1], am[0]}),
    .ld_start      (ld_start),
    .ld_start_addr (ld_start_addr),
    .ld_flash_ofs  (ld_flash_ofs),
    .ld_amount     (ld_amount),
    .ld_busy       (ld_busy),
    .ld_req        (ld_req),
    .ld_ack        (ld_ack),
    .ld_a          (ld_a),
    .ld_q          (ld_q),
    .wr_strobe     (wr_strobe),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_region     (wr_region),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .c64_reset_hold(c64_reset_hold)
  );

  // Each loaded byte i of a region carries address i and data i*7 + low byte of its start address.
  always @(negedge clk) begin
    if (ld_start === 1'b1) begin
      n_starts <= n_starts + 1;
      cur_i    <= 0;
    end else if (wr_strobe === 1'b1) begin
      cur_i <= cur_i + 1;
    end
    if (wr_strobe === 1'b1) begin
      n_str <= n_str + 1;
      if (wr_region === 3'd0) n_r0 <= n_r0 + 1;
      if (wr_region === 3'd1) n_r1 <= n_r1 + 1;
      if (mon_chk && (wr_addr !== A_BITS'(cur_i) ||
                      wr_data !== 8'(cur_i * 7 + int'(sa[wr_region[0]][7:0])))) begin
        mon_err <= mon_err + 1;
      end
    end
  end

  task automatic loader(input int nloads, input int gap, input int first);
    int          t;
    int          amt;
    logic [7:0]  seed;
    for (int l = 0; l < nloads; l++) begin
      int r = first + l;
      t = 0;
      while (ld_start !== 1'b1 && t < 100) begin
        @(posedge clk); #1;
        t++;
      end
      n_checks++;
      if (ld_start !== 1'b1) begin
        $display("FAIL loader_start%0d: ld_start %b, required 1 within 100 cycles", l, ld_start);
        return;
      end else n_pass++;
      n_checks++;
      if (ld_start_addr !== sa[r] || ld_flash_ofs !== of[r] || ld_amount !== am[r])
        $display("FAIL loader_desc%0d: got %h/%h/%h, required %h/%h/%h", l, ld_start_addr,
                 ld_flash_ofs, ld_amount, sa[r], of[r], am[r]);
      else n_pass++;
      amt  = int'(am[r]);
      seed = sa[r][7:0];
      @(posedge clk); #1 ld_busy = 1'b1;
      for (int i = 0; i < amt; i++) begin
        repeat (gap) @(posedge clk);
        #1;
        ld_a   = A_BITS'(i);
        ld_q   = 8'(i * 7 + int'(seed));
        ld_req = ~ld_req;
      end
      repeat (3) @(posedge clk);
      #1 ld_busy = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (c64_reset_hold !== 1'b1) $display("FAIL rst_hold: got %b, required 1", c64_reset_hold); else n_pass++;
    n_checks++; if ({busy, done, error, ld_start, wr_strobe, ld_ack} !== 6'b0)
      $display("FAIL rst_flags: got %b, required 000000", {busy, done, error, ld_start, wr_strobe, ld_ack});
    else n_pass++;
    n_checks++; if (ld_start_addr !== 16'h0 || ld_amount !== 16'h0 || wr_addr !== '0)
      $display("FAIL rst_regs: got %h/%h/%h, required 0/0/0", ld_start_addr, ld_amount, wr_addr);
    else n_pass++;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_idle: busy %b, required 0", busy); else n_pass++;
  endtask

  task automatic test_main();
    int b_r0 = n_r0, b_r1 = n_r1, b_str = n_str, b_st = n_starts, b_err = mon_err;
    sa[0] = 16'h8011; of[0] = 24'h010000; am[0] = 16'd8192;
    sa[1] = 16'hA0C3; of[1] = 24'h012000; am[1] = 16'd4096;
    mon_chk = 1'b1;
    fork
      loader(2, 4, 0);
      begin
        slot_valid = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b1 || ld_start !== 1'b0)
          $display("FAIL main_sel: busy/ld_start %b%b, required 10", busy, ld_start);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (ld_start !== 1'b1 || ld_start_addr !== 16'h8011 || ld_flash_ofs !== 24'h010000)
          $display("FAIL main_start: got %b %h %h, required 1 8011 010000", ld_start, ld_start_addr, ld_flash_ofs);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (ld_start !== 1'b0) $display("FAIL main_pulse: ld_start %b, required 0", ld_start); else n_pass++;
        slot_valid = 1'b0;
      end
    join
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (done !== 1'b0) $display("FAIL main_done_early: done %b, required 0", done); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b1 || c64_reset_hold !== 1'b0 || busy !== 1'b0)
      $display("FAIL main_done: done/hold/busy %b%b%b, required 100", done, c64_reset_hold, busy);
    else n_pass++;
    n_checks++; if (n_str - b_str !== 12288) $display("FAIL main_strobes: got %0d, required 12288", n_str - b_str); else n_pass++;
    n_checks++; if (n_r0 - b_r0 !== 8192 || n_r1 - b_r1 !== 4096)
      $display("FAIL main_regions: got %0d/%0d, required 8192/4096", n_r0 - b_r0, n_r1 - b_r1);
    else n_pass++;
    n_checks++; if (mon_err - b_err !== 0) $display("FAIL main_data: got %0d bad bytes, required 0", mon_err - b_err); else n_pass++;
    n_checks++; if (n_starts - b_st !== 2) $display("FAIL main_starts: got %0d, required 2", n_starts - b_st); else n_pass++;
  endtask

  task automatic test_skip();
    int b_r0 = n_r0, b_r1 = n_r1, b_st = n_starts, b_err = mon_err, t;
    sa[0] = 16'h4455; of[0] = 24'h020000; am[0] = 16'd0;
    sa[1] = 16'h6077; of[1] = 24'h034000; am[1] = 16'd5;
    fork
      loader(1, 2, 1);
      begin
        slot_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (ld_start !== 1'b0) $display("FAIL skip_early: ld_start %b, required 0", ld_start); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (ld_start !== 1'b1 || ld_start_addr !== 16'h6077 || ld_flash_ofs !== 24'h034000)
          $display("FAIL skip_start: got %b %h %h, required 1 6077 034000", ld_start, ld_start_addr, ld_flash_ofs);
        else n_pass++;
        slot_valid = 1'b0;
      end
    join
    t = 0;
    while (done !== 1'b1 && t < 20) begin @(posedge clk); #1; t++; end
    n_checks++; if (done !== 1'b1) $display("FAIL skip_done: done %b, required 1", done); else n_pass++;
    n_checks++; if (n_starts - b_st !== 1 || n_r0 - b_r0 !== 0 || n_r1 - b_r1 !== 5 || mon_err - b_err !== 0)
      $display("FAIL skip_counts: starts %0d r0 %0d r1 %0d err %0d, required 1 0 5 0",
               n_starts - b_st, n_r0 - b_r0, n_r1 - b_r1, mon_err - b_err);
    else n_pass++;
  endtask

  task automatic test_retrigger();
    int b_st = n_starts, b_r0, b_r1, b_err, t;
    sa[0] = 16'h1020; of[0] = 24'h000100; am[0] = 16'd4;
    sa[1] = 16'h3040; of[1] = 24'h000900; am[1] = 16'd3;
    fork
      loader(2, 4, 0);
      begin
        slot_valid = 1'b1;
        @(posedge clk); #1 slot_valid = 1'b0;
        repeat (15) @(posedge clk);
        #1 slot_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1 slot_valid = 1'b0;
        n_checks++; if (busy !== 1'b1) $display("FAIL retrig_busy: busy %b, required 1", busy); else n_pass++;
      end
    join
    t = 0;
    while (done !== 1'b1 && t < 20) begin @(posedge clk); #1; t++; end
    repeat (5) @(posedge clk);
    #1;
    n_checks++; if (done !== 1'b1 || busy !== 1'b0 || n_starts - b_st !== 2)
      $display("FAIL retrig_ignored: done %b busy %b starts %0d, required 1 0 2", done, busy, n_starts - b_st);
    else n_pass++;
    b_r0 = n_r0; b_r1 = n_r1; b_err = mon_err;
    slot_valid = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0 || c64_reset_hold !== 1'b1 || busy !== 1'b1)
      $display("FAIL retrig_drop: done/hold/busy %b%b%b, required 011", done, c64_reset_hold, busy);
    else n_pass++;
    slot_valid = 1'b0;
    loader(2, 2, 0);
    t = 0;
    while (done !== 1'b1 && t < 20) begin @(posedge clk); #1; t++; end
    n_checks++; if (done !== 1'b1 || n_r0 - b_r0 !== 4 || n_r1 - b_r1 !== 3 || mon_err - b_err !== 0)
      $display("FAIL retrig_second: done %b r0 %0d r1 %0d err %0d, required 1 4 3 0",
               done, n_r0 - b_r0, n_r1 - b_r1, mon_err - b_err);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int b_st, t;
    mon_chk = 1'b0;
    slot_valid = 1'b1;
    t = 0;
    while (ld_start !== 1'b1 && t < 20) begin @(posedge clk); #1; t++; end
    @(posedge clk); #1 ld_busy = 1'b1;
    ld_a = A_BITS'(5); ld_q = 8'h3C; ld_req = ~ld_req;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b1 || wr_data !== 8'h3C)
      $display("FAIL mid_pre: busy %b wr_data %h, required 1 3c", busy, wr_data);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++; if ({busy, done, c64_reset_hold, ld_start, wr_strobe, ld_ack} !== 6'b001000)
      $display("FAIL mid_flags: got %b, required 001000", {busy, done, c64_reset_hold, ld_start, wr_strobe, ld_ack});
    else n_pass++;
    n_checks++; if (ld_start_addr !== 16'h0 || ld_amount !== 16'h0 || wr_data !== 8'h0 || wr_addr !== '0)
      $display("FAIL mid_regs: got %h/%h/%h/%h, required 0/0/0/0", ld_start_addr, ld_amount, wr_data, wr_addr);
    else n_pass++;
    ld_busy = 1'b0; ld_req = 1'b0; ld_a = '0; ld_q = 8'h0;
    @(posedge clk); #1 reset = 1'b0;
    b_st = n_starts;
    repeat (10) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0 || n_starts !== b_st)
      $display("FAIL mid_no_restart: busy %b starts %0d, required 0 0", busy, n_starts - b_st);
    else n_pass++;
    slot_valid = 1'b0;
    @(posedge clk); #1 slot_valid = 1'b1;
    mon_chk = 1'b1;
    loader(2, 2, 0);
    slot_valid = 1'b0;
    t = 0;
    while (done !== 1'b1 && t < 20) begin @(posedge clk); #1; t++; end
    n_checks++; if (done !== 1'b1) $display("FAIL mid_rearm: done %b, required 1", done); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [A_BITS-1:0] ea;
    logic [7:0]        ed;
    logic              er;
    int                bad = 0;
    mon_chk = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ea = A_BITS'(200 + 3 * i);
      ed = 8'hC0 ^ 8'(i);
      ld_a = ea; ld_q = ed; ld_req = ~ld_req; er = ld_req;
      @(posedge clk); #1;
      n_checks++;
      if (wr_strobe !== 1'b1 || wr_addr !== ea || wr_data !== ed || wr_region !== 3'd1 || ld_ack !== er) begin
        $display("FAIL b2b_%0d: got %b %h %h %0d ack %b, required 1 %h %h 1 ack %b",
                 i, wr_strobe, wr_addr, wr_data, wr_region, ld_ack, ea, ed, er);
        bad++;
      end else n_pass++;
    end
    @(posedge clk); #1;
    n_checks++; if (wr_strobe !== 1'b0 || wr_addr !== A_BITS'(221))
      $display("FAIL b2b_stop: strobe %b addr %h, required 0 %h", wr_strobe, wr_addr, A_BITS'(221));
    else n_pass++;
  endtask

  task automatic test_watchdog();
    int b_st = n_starts, t;
    sa[0] = 16'h5000; of[0] = 24'h000000; am[0] = 16'd2;
    sa[1] = 16'h7000; of[1] = 24'h004000; am[1] = 16'd2;
    slot_valid = 1'b1;
    t = 0;
    while (ld_start !== 1'b1 && t < 20) begin @(posedge clk); #1; t++; end
    @(posedge clk); #1;
    ld_busy = 1'b1; ena_1khz = 1'b1; slot_valid = 1'b0;
`ifdef ROM_LOAD_WATCHDOG_EN
    t = 0;
    while (ld_start !== 1'b1 && t < 2100) begin @(posedge clk); #1; t++; end
    n_checks++; if (ld_start !== 1'b1 || error !== 1'b1 || ld_start_addr !== 16'h7000)
      $display("FAIL wd_next: ld_start %b error %b addr %h, required 1 1 7000", ld_start, error, ld_start_addr);
    else n_pass++;
    t = 0;
    while (done !== 1'b1 && t < 2100) begin @(posedge clk); #1; t++; end
    n_checks++; if (done !== 1'b1 || error !== 1'b1)
      $display("FAIL wd_done: done %b error %b, required 1 1", done, error);
    else n_pass++;
    ld_busy = 1'b0; ena_1khz = 1'b0;
    slot_valid = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (error !== 1'b0) $display("FAIL wd_clear: error %b, required 0", error); else n_pass++;
    slot_valid = 1'b0;
`else
    repeat (2100) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b1 || done !== 1'b0 || error !== 1'b0 || n_starts - b_st !== 1)
      $display("FAIL wd_stuck: busy %b done %b error %b starts %0d, required 1 0 0 1",
               busy, done, error, n_starts - b_st);
    else n_pass++;
    ld_busy = 1'b0; ena_1khz = 1'b0;
`endif
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ena_1khz = 1'b0; slot_valid = 1'b0;
    ld_busy = 1'b0; ld_req = 1'b0; ld_a = '0; ld_q = 8'h0;
    sa[0] = 16'h0; sa[1] = 16'h0; of[0] = '0; of[1] = '0; am[0] = 16'h0; am[1] = 16'h0;
    test_reset();
    test_main();
    test_skip();
    test_retrigger();
    test_reset_mid();
    test_back_to_back();
    test_watchdog();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rom_load_sequencer.md
# rom_load_sequencer

Multi-region boot loader sequencer. It sits between the USB flash-slot report, the SPI flash loader and the cartridge/REU block RAMs. On a rising edge of the slot-valid flag it runs up to `NUM_REGIONS` flash loads back to back, converts the loader's toggle handshake into single-cycle write strobes tagged with the region index, and holds the C64 in reset until every region is in place. It generalises the single fixed 8 KiB ROM load with per-region address, offset and length, zero-length skipping, re-trigger and an optional watchdog.

## Interface
Parameters:
- `NUM_REGIONS`, default 2: number of region descriptors, 1..8.
- `A_BITS`, default 14: loader write-address width.
- `OFS_BITS`, default 24: flash byte offset width.

Ports:
- `clk` in 1: system clock, 100 MHz.
- `reset` in 1: asynchronous, active-high.
- `ena_1khz` in 1: one-cycle 1 kHz tick; used only with the watchdog.
- `slot_valid` in 1: flash slot report valid; a rising edge starts a sequence.
- `reg_start_addr` in `NUM_REGIONS*16`: per-region target start address; region i is at bits [16i+15:16i].
- `reg_flash_ofs` in `NUM_REGIONS*OFS_BITS`: per-region flash offset.
- `reg_amount` in `NUM_REGIONS*16`: per-region byte count; 0 means skip the region.
- `ld_start` out 1: one-cycle start pulse to the flash loader.
- `ld_start_addr` out 16: loader start address, registered.
- `ld_flash_ofs` out `OFS_BITS`: loader flash offset, registered.
- `ld_amount` out 16: loader byte count, registered.
- `ld_busy` in 1: loader busy.
- `ld_req` in 1: loader toggle request.
- `ld_ack` out 1: toggle acknowledge.
- `ld_a` in `A_BITS`: loader write address.
- `ld_q` in 8: loader write data.
- `wr_strobe` out 1: one-cycle BRAM write enable.
- `wr_addr` out `A_BITS`: BRAM write address.
- `wr_data` out 8: BRAM write data.
- `wr_region` out 3: index of the region being written.
- `busy` out 1: a sequence is in progress.
- `done` out 1: the last sequence completed.
- `error` out 1: watchdog fired; always 0 when the watchdog is compiled out.
- `c64_reset_hold` out 1: equals `~done`; feeds the reset_c64 input of the I/O shift register.

## Operation
- Edge detection: `slot_valid` is registered into `sv_old`; the trigger is `slot_valid & ~sv_old`.
- States and transitions:
  - IDLE: on trigger, set idx=0 and go to SELECT.
  - SELECT: if `reg_amount[idx]`==0, go to NEXT. Otherwise latch the descriptor into the `ld_*` outputs and go to START.
  - START: assert `ld_start` for one cycle, go to WAIT_BUSY.
  - WAIT_BUSY: when `ld_busy`=1, go to WAIT_DONE.
  - WAIT_DONE: when `ld_busy`=0, go to NEXT.
  - NEXT: if idx==`NUM_REGIONS`-1, go to FINISH. Otherwise idx+1 and go to SELECT.
  - FINISH: set `done`=1 and go to IDLE.
- `busy`=1 in every state except IDLE.
- Re-trigger:
  - A trigger in IDLE with `done`=1 clears `done` and `error` and restarts at idx 0.
  - A trigger while `busy` is ignored.
- Write path, active in every state:
  - When `ld_req`!=`req_old`, assert `wr_strobe` for one cycle with `wr_addr`=`ld_a`, `wr_data`=`ld_q` and `wr_region`=idx, all registered.
  - `ld_ack` is `ld_req` delayed by one register.
  - `req_old` is updated every cycle.
- Reset values:
  - All outputs are 0 except `c64_reset_hold`, which is 1.
  - Internally: state=IDLE, idx=0, `sv_old`=0, `req_old`=0.
- Reset mid-sequence aborts immediately and drops `done`. If `slot_valid` is already high, no new sequence starts until it falls and rises again.

## Timing
- Trigger at edge N: SELECT at N+1, `ld_start` high during N+2.
- `ld_*` descriptor outputs are stable from N+2 and stay unchanged until the next SELECT.
- Zero-length region: SELECT→NEXT costs 2 cycles per skipped region.
- `ld_req` toggle seen at edge k: `wr_strobe`, `wr_addr`, `wr_data` are valid during cycle k+1 and `ld_ack` matches at k+1. Sustained rate is one byte per cycle.
- `done` rises 1 cycle after the last `ld_busy` fall is sampled in WAIT_DONE, plus 1 cycle through NEXT and FINISH.

## Configuration
- `ROM_LOAD_WATCHDOG_EN` defined:
  - A 12-bit ms counter clears on entry to WAIT_BUSY and increments on `ena_1khz` while in WAIT_BUSY or WAIT_DONE.
  - At 2000 the block sets `error`=1 (sticky until the next trigger) and skips to NEXT.
  - The sequence then continues and still ends with `done`=1.
- Undefined: no counter. `error` is tied to 0, and the block waits on `ld_busy` indefinitely.

## Test plan
- NUM_REGIONS=2 with amounts 8192 and 4096; loader model emits one toggle every 4 cycles → exactly 12288 `wr_strobe` pulses, `wr_region` 0 then 1, `done`=1 and `c64_reset_hold`=0 at the end.
- Region 0 amount=0 → only one `ld_start` pulse, carrying region 1's start address and offset; the skip costs 2 cycles.
- `slot_valid` pulses again mid-load → ignored. Pulse after `done` → `done` drops for the cycle after the trigger and a second full sequence runs.
- Assert `reset` asynchronously during WAIT_DONE → all outputs return to reset values that same cycle with `c64_reset_hold`=1. Holding `slot_valid` high through reset release starts no sequence.
- Back-to-back `ld_req` toggles every cycle → one `wr_strobe` per toggle with correct address and data, and `ld_ack` tracks `ld_req` with 1-cycle lag.
- With `ROM_LOAD_WATCHDOG_EN`, `ld_busy` stuck at 1 → after 2000 `ena_1khz` ticks `error`=1 and the next region starts. Without the macro, the block stays in WAIT_DONE.
